// File: rtl/addr_seq_unit_pkg.sv
// Shared definitions for the address sequencer: command encodings, FSM states,
// default parameter values and a small sign-extension helper.
package addr_seq_unit_pkg;

    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH      = 26;
    localparam int DEF_INST_START_ADDR = 0;
    localparam int DEF_STACK_DEPTH     = 256;

    typedef enum logic [2:0] {
        OP_PC_INC  = 3'd0,
        OP_BR_REL  = 3'd1,
        OP_JMP_ABS = 3'd2,
        OP_JMP_REG = 3'd3,
        OP_PUSH    = 3'd4,
        OP_POP     = 3'd5,
        OP_FETCH   = 3'd6,
        OP_NOP     = 3'd7
    } cmd_op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_e;

    // Branch offsets are 16-bit signed; callers truncate to the address width.
    function automatic logic [63:0] sext16(input logic [15:0] v);
        return {{48{v[15]}}, v};
    endfunction

endpackage

// File: rtl/addr_seq_unit_if.sv
// Command and memory bus bundle; master is the environment, slave is the sequencer.
interface addr_seq_unit_if
    import addr_seq_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [DATA_WIDTH-1:0] cmd_imm;
    logic [DATA_WIDTH-1:0] cmd_reg;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output cmd_valid, cmd_op, cmd_imm, cmd_reg, mem_ack, mem_rdata,
        input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_imm, cmd_reg, mem_ack, mem_rdata,
        output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/addr_seq_unit_reg_pp_param.sv
// Load-enabled register with a parametrised reset preset; holds PC and SP.
module addr_seq_unit_reg_pp_param #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] PRESET = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] val_q;

    // Preset on reset, otherwise load when enabled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            val_q <= PRESET;
        end else if (load_i) begin
            val_q <= d_i;
        end else begin
            val_q <= val_q;
        end
    end

    assign q_o = val_q;
endmodule

// File: rtl/addr_seq_unit.sv
// Program-counter / stack-pointer sequencer: single-cycle PC updates, and
// push/pop/fetch commands issued as one outstanding memory transaction.
module addr_seq_unit
    import addr_seq_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] INST_START_ADDR = ADDR_WIDTH'(DEF_INST_START_ADDR),
    parameter logic [ADDR_WIDTH-1:0] STACK_TOP       = {ADDR_WIDTH{1'b1}},
    parameter int                    STACK_DEPTH     = DEF_STACK_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    addr_seq_unit_if.slave        bus,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] sp_o,
    output logic                  ovf_o,
    output logic                  udf_o
);
    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(STACK_DEPTH);

    state_e                state_q, state_d;
    cmd_op_e               op_q, op_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  pc_ld_d, sp_ld_d;
    logic [ADDR_WIDTH-1:0] pc_d, sp_d, pc_q, sp_q;

    cmd_op_e               cmd_op_s;
    logic                  stack_full_s;
    logic                  unused_cmd_bits;

    assign cmd_op_s     = cmd_op_e'(bus.cmd_op);
    // Occupancy is measured downward from STACK_TOP, modulo the address space.
    assign stack_full_s = ((STACK_TOP - sp_q) == DEPTH_W);
    assign unused_cmd_bits = ^{bus.cmd_imm, bus.cmd_reg};

    addr_seq_unit_reg_pp_param #(.WIDTH(ADDR_WIDTH), .PRESET(INST_START_ADDR)) u_pc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (pc_ld_d),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

    addr_seq_unit_reg_pp_param #(.WIDTH(ADDR_WIDTH), .PRESET(STACK_TOP)) u_sp (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (sp_ld_d),
        .d_i    (sp_d),
        .q_o    (sp_q)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, bus request and PC/SP update decisions.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        ovf_d         = ovf_q;
        udf_d         = udf_q;
        pc_ld_d       = 1'b0;
        pc_d          = pc_q;
        sp_ld_d       = 1'b0;
        sp_d          = sp_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d = cmd_op_s;
                    case (cmd_op_s)
                        OP_PC_INC: begin
                            pc_ld_d = 1'b1;
                            pc_d    = pc_q + ONE;
                        end
                        OP_BR_REL: begin
                            pc_ld_d = 1'b1;
                            pc_d    = pc_q + ONE + ADDR_WIDTH'(sext16(bus.cmd_imm[15:0]));
                        end
                        OP_JMP_ABS: begin
                            pc_ld_d = 1'b1;
                            pc_d    = bus.cmd_imm[ADDR_WIDTH-1:0];
                        end
                        OP_JMP_REG: begin
                            pc_ld_d = 1'b1;
                            pc_d    = bus.cmd_reg[ADDR_WIDTH-1:0];
                        end
                        OP_PUSH: begin
                            if (stack_full_s) begin
                                ovf_d = 1'b1;
                            end else begin
                                state_d     = ST_WAIT_ACK;
                                mem_req_d   = 1'b1;
                                mem_we_d    = 1'b1;
                                mem_addr_d  = sp_q;
                                mem_wdata_d = bus.cmd_reg;
                            end
                        end
                        OP_POP: begin
                            if (sp_q == STACK_TOP) begin
                                udf_d = 1'b1;
                            end else begin
                                state_d    = ST_WAIT_ACK;
                                mem_req_d  = 1'b1;
                                mem_we_d   = 1'b0;
                                mem_addr_d = sp_q + ONE;
                            end
                        end
                        OP_FETCH: begin
                            state_d    = ST_WAIT_ACK;
                            mem_req_d  = 1'b1;
                            mem_we_d   = 1'b0;
                            mem_addr_d = pc_q;
                        end
                        OP_NOP: begin
                            op_d = op_q;
                        end
                        default: begin
                            op_d = op_q;
                        end
                    endcase
                end else begin
                    op_d = op_q;
                end
            end
            ST_WAIT_ACK: begin
                if (bus.mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    case (op_q)
                        OP_PUSH: begin
                            sp_ld_d = 1'b1;
                            sp_d    = sp_q - ONE;
                        end
                        OP_POP: begin
                            sp_ld_d       = 1'b1;
                            sp_d          = sp_q + ONE;
                            rdata_d       = bus.mem_rdata;
                            rdata_valid_d = 1'b1;
                        end
                        OP_FETCH: begin
                            rdata_d       = bus.mem_rdata;
                            rdata_valid_d = 1'b1;
                        end
                        default: begin
                            rdata_valid_d = 1'b0;
                        end
                    endcase
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    // Registered bus, status and read-data outputs; reset overrides any completion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q          <= OP_NOP;
            cmd_ready_q   <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            ovf_q         <= 1'b0;
            udf_q         <= 1'b0;
        end else begin
            op_q          <= op_d;
            cmd_ready_q   <= cmd_ready_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            ovf_q         <= ovf_d;
            udf_q         <= udf_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign pc_o          = pc_q;
    assign sp_o          = sp_q;
    assign ovf_o         = ovf_q;
    assign udf_o         = udf_q;
endmodule

// File: tb/tb_addr_seq_unit.sv
// Bench for addr_seq_unit: a PC/SP/flag model plus a read-data scoreboard fed
// when reads are issued and drained when RDATA_VALID appears.
module tb_addr_seq_unit;
    import addr_seq_unit_pkg::*;

    localparam int              DW    = 32;
    localparam int              AW    = 26;
    localparam logic [AW-1:0]   TOP   = {AW{1'b1}};
    localparam logic [AW-1:0]   START = '0;
    localparam int              DEPTH = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addr_seq_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic [AW-1:0] pc, sp;
    logic          ovf, udf;

    addr_seq_unit #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INST_START_ADDR(START),
        .STACK_TOP(TOP), .STACK_DEPTH(DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus.slave),
        .rdata_o       (rdata),
        .rdata_valid_o (rdata_valid),
        .pc_o          (pc),
        .sp_o          (sp),
        .ovf_o         (ovf),
        .udf_o         (udf)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    logic [AW-1:0] m_pc, m_sp;
    logic          m_ovf, m_udf;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {6'd0, a} ^ 32'hC0DE_0000;
    endfunction

    task automatic model_reset();
        m_pc  = START;
        m_sp  = TOP;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        exp_q.delete();
    endtask

    // Scoreboard drain: every read-data pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (rdata_valid === 1'b1) begin
            if (exp_q.size() == 0) check_eq("rdata_unexpected", 64'd1, 64'd0);
            else check_eq("rdata", 64'(rdata), 64'(exp_q.pop_front()));
        end
    end

    task automatic check_state(input string tag);
        check_eq({tag, "_pc"},  64'(pc),  64'(m_pc));
        check_eq({tag, "_sp"},  64'(sp),  64'(m_sp));
        check_eq({tag, "_ovf"}, 64'(ovf), 64'(m_ovf));
        check_eq({tag, "_udf"}, 64'(udf), 64'(m_udf));
    endtask

    // Memory responder: acknowledges in the delay-th cycle of the request.
    task automatic serve(input int delay, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, output int held);
        bit done;
        held = 0;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (bus.mem_req !== 1'b1) begin
                done = 1'b1;
            end else begin
                held++;
                check_eq("mem_we",   64'(bus.mem_we),   64'(we));
                check_eq("mem_addr", 64'(bus.mem_addr), 64'(a));
                if (we) check_eq("mem_wdata", 64'(bus.mem_wdata), 64'(wd));
                if (held == delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = we ? 32'h0000_0000 : mem_read(a);
                    bus.cmd_valid = 1'b0;
                end
                @(negedge clk);
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'hDEAD_BEEF;
            end
        end
        if (!done) check_eq("serve_timeout", 64'd0, 64'd1);
    endtask

    // Issue one command, update the model, and check the outcome after it settles.
    task automatic run(input logic [2:0] op, input logic [DW-1:0] imm,
                       input logic [DW-1:0] regv, input int delay, input bit poke);
        bit            mem_op;
        logic          we;
        logic [AW-1:0] a;
        int            held;
        mem_op = 1'b0;
        we     = 1'b0;
        a      = '0;
        check_eq("cmd_ready", 64'(bus.cmd_ready), 64'd1);
        case (op)
            3'd0: m_pc = m_pc + AW'(1);
            3'd1: m_pc = m_pc + AW'(1) + {{(AW-16){imm[15]}}, imm[15:0]};
            3'd2: m_pc = imm[AW-1:0];
            3'd3: m_pc = regv[AW-1:0];
            3'd4: begin
                if (TOP - m_sp == AW'(DEPTH)) m_ovf = 1'b1;
                else begin mem_op = 1'b1; we = 1'b1; a = m_sp; mem_model[a] = regv; end
            end
            3'd5: begin
                if (m_sp == TOP) m_udf = 1'b1;
                else begin mem_op = 1'b1; a = m_sp + AW'(1); exp_q.push_back(mem_read(a)); end
            end
            3'd6: begin mem_op = 1'b1; a = m_pc; exp_q.push_back(mem_read(a)); end
            default: ;
        endcase
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_imm   = imm;
        bus.cmd_reg   = regv;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (mem_op) begin
            if (poke) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 3'd0;
            end
            serve(delay, we, a, regv, held);
            check_eq("req_cycles", 64'(held), 64'(delay));
            if (op == 3'd4) m_sp = m_sp - AW'(1);
            else if (op == 3'd5) m_sp = m_sp + AW'(1);
        end else begin
            check_eq("no_req", 64'(bus.mem_req), 64'd0);
        end
        check_state("post");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd7;
        bus.cmd_imm   = '0;
        bus.cmd_reg   = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        rst           = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check_eq("rst_mem_req",   64'(bus.mem_req),   64'd0);
        check_eq("rst_mem_we",    64'(bus.mem_we),    64'd0);
        check_eq("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
        check_eq("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check_eq("rst_rdata",     64'(rdata),         64'd0);
        check_eq("rst_rvalid",    64'(rdata_valid),   64'd0);
        check_eq("rst_ready",     64'(bus.cmd_ready), 64'd1);
        check_state("rst");

        // PC_INC x3 then BR_REL -2: 1,2,3 then 2.
        for (int i = 0; i < 3; i++) run(3'd0, 32'd0, 32'd0, 1, 1'b0);
        check_eq("pc_after_inc", 64'(pc), 64'd3);
        run(3'd1, 32'h0000_FFFE, 32'd0, 1, 1'b0);
        check_eq("pc_after_br", 64'(pc), 64'd2);

        // ACK while idle must be ignored.
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check_state("stray_ack");

        // Push with 3-cycle ACK delay, then pop it back.
        run(3'd4, 32'd0, 32'h0000_00A5, 3, 1'b0);
        check_eq("sp_after_push", 64'(sp), 64'h3FF_FFFE);
        run(3'd5, 32'd0, 32'd0, 1, 1'b0);
        check_eq("sp_after_pop", 64'(sp), 64'h3FF_FFFF);
        @(negedge clk);
        check_eq("rvalid_one_cycle", 64'(rdata_valid), 64'd0);
        check_eq("rdata_hold",       64'(rdata),       64'h0000_00A5);

        // Underflow on empty stack.
        run(3'd5, 32'd0, 32'd0, 1, 1'b0);
        check_eq("udf_set", 64'(udf), 64'd1);

        // Fetches, one with a command offered while waiting (must not be taken).
        run(3'd6, 32'd0, 32'd0, 2, 1'b1);
        run(3'd2, 32'h0000_1234, 32'd0, 1, 1'b0);
        run(3'd6, 32'd0, 32'd0, 4, 1'b0);
        run(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);

        // Fill the stack, then the overflowing push.
        for (int i = 0; i < DEPTH; i++) run(3'd4, 32'd0, 32'h1000_0000 + i, 1 + (i % 2), 1'b0);
        check_eq("sp_full", 64'(sp), 64'(TOP - AW'(DEPTH)));
        run(3'd4, 32'd0, 32'hBAD0_0000, 1, 1'b0);
        check_eq("ovf_set", 64'(ovf), 64'd1);
        run(3'd5, 32'd0, 32'd0, 2, 1'b0);
        run(3'd5, 32'd0, 32'd0, 1, 1'b0);
        run(3'd4, 32'd0, 32'h0000_5A5A, 1, 1'b0);
        run(3'd5, 32'd0, 32'd0, 1, 1'b0);
        check_eq("ovf_sticky", 64'(ovf), 64'd1);
        check_eq("udf_sticky", 64'(udf), 64'd1);

        // PC wrap, register jump.
        run(3'd2, 32'h03FF_FFFF, 32'd0, 1, 1'b0);
        run(3'd0, 32'd0, 32'd0, 1, 1'b0);
        check_eq("pc_wrap", 64'(pc), 64'd0);
        run(3'd3, 32'd0, 32'hFC00_0123, 1, 1'b0);
        check_eq("pc_jmp_reg", 64'(pc), 64'h123);

        // Reset during WAIT_ACK with simultaneous ACK aborts the fetch.
        check_eq("abort_ready", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd6;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check_eq("abort_req_before", 64'(bus.mem_req), 64'd1);
        rst           = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        rst         = 1'b0;
        bus.mem_ack = 1'b0;
        model_reset();
        check_eq("abort_req",    64'(bus.mem_req),   64'd0);
        check_eq("abort_rvalid", 64'(rdata_valid),   64'd0);
        check_eq("abort_rdata",  64'(rdata),         64'd0);
        check_state("abort");
        @(negedge clk);
        check_eq("abort_rvalid2", 64'(rdata_valid), 64'd0);
        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
